// File: rtl/pe_issue_ctrl_if.sv
// Command and response streams between dispatch logic and pe_issue_ctrl.
// slave is the controller side, master is the dispatch/consumer side.
interface pe_issue_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_opcode;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;
  logic [7:0]       rsp_tag;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_tag
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_tag
  );
endinterface

// File: rtl/pe_issue_ctrl.sv
// Queues PE commands, issues them one at a time to a combinational PE,
// waits SETTLE cycles and returns the captured result with a sequence tag.
module pe_issue_ctrl #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pe_issue_ctrl_if.slave           io,
  output logic [3:0]               pe_opcode,
  output logic [WIDTH-1:0]         pe_a,
  output logic [WIDTH-1:0]         pe_b,
  input  logic [WIDTH-1:0]         pe_result,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [7:0]       tag;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  cmd_t             mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [7:0]       tag_cnt;
  logic             full, empty, push, pop;
  cmd_t             head;
  logic             head_legal;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [7:0]       cur_tag;
  logic             load_pe, load_err, capture, rsp_clr;

  logic             rsp_valid_q, rsp_err_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic [7:0]       rsp_tag_q;

  assign full         = (count == (AW+1)'(DEPTH));
  assign empty        = (count == '0);
  // No passthrough: a full FIFO refuses even when the head pops this cycle.
  assign io.cmd_ready = rst_n && !full;
  assign push         = io.cmd_valid && io.cmd_ready;
  assign pop          = (state == IDLE) && !empty;
  assign head         = mem[rd_ptr];
  assign head_legal   = (head.op == 4'b0001 || head.op == 4'b0011 ||
                         head.op == 4'b0101 || head.op == 4'b0111) &&
                        !(head.op == 4'b0111 && head.b == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: io.cmd_opcode, a: io.cmd_a, b: io.cmd_b, tag: tag_cnt};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tag_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        tag_cnt <= tag_cnt + 8'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_pe   = 1'b0;
    load_err  = 1'b0;
    capture   = 1'b0;
    rsp_clr   = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        if (head_legal) begin
          load_pe   = 1'b1;
          state_nxt = ISSUE;
        end else begin
          load_err  = 1'b1;
          state_nxt = RESP;
        end
      end
      ISSUE: if (cnt == '0) begin
        capture   = 1'b1;
        state_nxt = RESP;
      end
      RESP: if (rsp_valid_q && io.rsp_ready) begin
        rsp_clr   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // pe_* only change on a legal issue so the PE inputs never glitch between commands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_opcode   <= '0;
      pe_a        <= '0;
      pe_b        <= '0;
      cnt         <= '0;
      cur_tag     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
    end else begin
      if (load_pe) begin
        pe_opcode <= head.op;
        pe_a      <= head.a;
        pe_b      <= head.b;
        cnt       <= CW'(SETTLE-1);
        cur_tag   <= head.tag;
      end else if (state == ISSUE && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (load_err) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= 1'b1;
        rsp_data_q  <= '0;
        rsp_tag_q   <= head.tag;
      end else if (capture) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= 1'b0;
        rsp_data_q  <= pe_result;
        rsp_tag_q   <= cur_tag;
      end else if (rsp_clr) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign io.rsp_valid = rsp_valid_q;
  assign io.rsp_err   = rsp_err_q;
  assign io.rsp_data  = rsp_data_q;
  assign io.rsp_tag   = rsp_tag_q;
  assign busy         = (state != IDLE) || !empty;
  assign fifo_level   = count;
endmodule

// File: tb/tb_pe_issue_ctrl.sv
// Bench for pe_issue_ctrl: a stand-in PE plus an in-order response model fed at acceptance.
module tb_pe_issue_ctrl;
  localparam int WIDTH  = 16;
  localparam int DEPTH  = 4;
  localparam int SETTLE = 1;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             err;
    logic [7:0]       tag;
  } rsp_t;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [3:0]             pe_opcode;
  logic [WIDTH-1:0]       pe_a, pe_b, pe_result;
  logic                   busy;
  logic [$clog2(DEPTH):0] fifo_level;

  int          errors = 0;
  int          checks = 0;
  rsp_t        exp_q[$];
  logic [7:0]  tb_tag = 8'd0;

  pe_issue_ctrl_if #(.WIDTH(WIDTH)) io();

  pe_issue_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .io(io),
    .pe_opcode(pe_opcode), .pe_a(pe_a), .pe_b(pe_b), .pe_result(pe_result),
    .busy(busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] pe_fn(input logic [3:0] op, input logic [WIDTH-1:0] a, b);
    logic [2*WIDTH-1:0] p;
    p = a * b;
    case (op)
      4'b0001: return a + b;
      4'b0011: return a - b;
      4'b0101: return p[WIDTH-1:0];
      4'b0111: return (b == '0) ? '0 : a / b;
      default: return '0;
    endcase
  endfunction

  assign pe_result = pe_fn(pe_opcode, pe_a, pe_b);

  function automatic rsp_t model(input logic [3:0] op, input logic [WIDTH-1:0] a, b, input logic [7:0] tag);
    rsp_t r;
    bit   legal;
    legal  = (op == 4'd1 || op == 4'd3 || op == 4'd5 || op == 4'd7) && !(op == 4'd7 && b == '0);
    r.data = legal ? pe_fn(op, a, b) : '0;
    r.err  = !legal;
    r.tag  = tag;
    return r;
  endfunction

  task automatic set_cmd(input bit v, input logic [3:0] op, input logic [WIDTH-1:0] a, b);
    io.cmd_valid  = v;
    io.cmd_opcode = op;
    io.cmd_a      = a;
    io.cmd_b      = b;
  endtask

  // Sample what the coming edge will do, record accepted commands, advance one cycle.
  task automatic step(output bit acc, output bit vld, output bit hs, output rsp_t got, output int lvl);
    acc = io.cmd_valid && io.cmd_ready;
    vld = io.rsp_valid;
    hs  = io.rsp_valid && io.rsp_ready;
    got = {io.rsp_data, io.rsp_err, io.rsp_tag};
    lvl = int'(fifo_level);
    if (acc) begin
      exp_q.push_back(model(io.cmd_opcode, io.cmd_a, io.cmd_b, tb_tag));
      tb_tag = tb_tag + 8'd1;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    set_cmd(0, 4'd0, '0, '0);
    rst_n = 1'b0;
    exp_q.delete();
    tb_tag = 8'd0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    set_cmd(0, 4'd0, '0, '0);
    io.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({io.rsp_valid, io.rsp_err, io.rsp_data, io.rsp_tag, busy, fifo_level,
         pe_opcode, pe_a, pe_b, io.cmd_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs rsp_valid=%b busy=%b level=%0d pe_op=%h cmd_ready=%b (want all 0)",
               io.rsp_valid, busy, fifo_level, pe_opcode, io.cmd_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (io.cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release cmd_ready=%b busy=%b want 1/0", io.cmd_ready, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic_add;
    bit acc, vld, hs; rsp_t got; int lvl;
    io.rsp_ready = 1'b1;
    set_cmd(1, 4'b0001, 16'h1234, 16'h5678);
    step(acc, vld, hs, got, lvl);
    io.cmd_valid = 1'b0;
    checks++;
    if (!acc) begin errors++; $display("FAIL basic_accept acc=%b want 1", acc); end
    step(acc, vld, hs, got, lvl);
    checks++;
    if (pe_opcode !== 4'b0001 || pe_a !== 16'h1234 || pe_b !== 16'h5678 || io.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_issue pe=%h/%h/%h rsp_valid=%b want 1/1234/5678/0", pe_opcode, pe_a, pe_b, io.rsp_valid);
    end
    step(acc, vld, hs, got, lvl);
    checks++;
    if (io.rsp_valid !== 1'b1 || io.rsp_data !== 16'h68AC || io.rsp_err !== 1'b0 || io.rsp_tag !== 8'h00) begin
      errors++;
      $display("FAIL basic_rsp valid=%b data=%h err=%b tag=%h want 1/68ac/0/00",
               io.rsp_valid, io.rsp_data, io.rsp_err, io.rsp_tag);
    end
    step(acc, vld, hs, got, lvl);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    checks++;
    if (!hs || io.rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done hs=%b rsp_valid=%b busy=%b want 1/0/0", hs, io.rsp_valid, busy);
    end
  endtask

  task automatic test_back_to_back;
    bit acc, vld, hs; rsp_t got; int lvl;
    int n = 0, t0 = 0;
    rsp_t e;
    io.rsp_ready = 1'b1;
    set_cmd(1, 4'b0011, 16'h1234, 16'h5678);
    step(acc, vld, hs, got, lvl);
    set_cmd(1, 4'b0101, 16'h0003, 16'h0004);
    step(acc, vld, hs, got, lvl);
    io.cmd_valid = 1'b0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      step(acc, vld, hs, got, lvl);
      if (hs) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        checks++;
        if (got !== e || got.data !== ((n == 0) ? 16'hBBBC : 16'h000C)) begin
          errors++;
          $display("FAIL b2b_rsp%0d got=%h want=%h", n, got, e);
        end
        if (n == 1) begin
          checks++;
          if (c - t0 != 3) begin errors++; $display("FAIL b2b_spacing got=%0d want=3", c - t0); end
        end
        t0 = c;
        n++;
      end
    end
    checks++;
    if (n != 2) begin errors++; $display("FAIL b2b_count got=%0d want=2", n); end
  endtask

  task automatic test_errors;
    bit acc, vld, hs; rsp_t got; int lvl;
    int n = 0;
    rsp_t e;
    io.rsp_ready = 1'b1;
    set_cmd(1, 4'b0111, 16'h1234, 16'h0000);
    step(acc, vld, hs, got, lvl);
    set_cmd(1, 4'b0010, 16'h0001, 16'h0001);
    step(acc, vld, hs, got, lvl);
    io.cmd_valid = 1'b0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      step(acc, vld, hs, got, lvl);
      if (hs) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        checks++;
        if (got !== e || got.err !== 1'b1 || got.data !== '0) begin
          errors++;
          $display("FAIL err_rsp%0d got=%h want=%h", n, got, e);
        end
        checks++;
        if (pe_opcode !== 4'b0101 || pe_a !== 16'h0003 || pe_b !== 16'h0004) begin
          errors++;
          $display("FAIL err_pe_hold pe=%h/%h/%h want 5/0003/0004", pe_opcode, pe_a, pe_b);
        end
        n++;
      end
    end
    checks++;
    if (n != 2) begin errors++; $display("FAIL err_count got=%0d want=2", n); end
  endtask

  task automatic test_backpressure;
    bit acc, vld, hs; rsp_t got; int lvl;
    int nacc = 0, nhs = 0;
    rsp_t e;
    io.rsp_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      set_cmd(nacc < 6, 4'b0001, WIDTH'($urandom), WIDTH'($urandom));
      step(acc, vld, hs, got, lvl);
      if (acc) nacc++;
      if (vld) begin
        checks++;
        if (exp_q.size() == 0 || got !== exp_q[0]) begin
          errors++;
          $display("FAIL bp_stall_stable got=%h want=%h", got, (exp_q.size() != 0) ? exp_q[0] : '1);
        end
      end
    end
    io.cmd_valid = 1'b0;
    checks++;
    if (nacc != 5 || io.cmd_ready !== 1'b0 || fifo_level !== 3'd4) begin
      errors++;
      $display("FAIL bp_full accepts=%0d cmd_ready=%b level=%0d want 5/0/4", nacc, io.cmd_ready, fifo_level);
    end
    io.rsp_ready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      step(acc, vld, hs, got, lvl);
      if (hs) begin
        checks++;
        if (lvl != exp_q.size() - 1) begin
          errors++;
          $display("FAIL bp_level got=%0d want=%0d", lvl, exp_q.size() - 1);
        end
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin errors++; $display("FAIL bp_drain got=%h want=%h", got, e); end
        nhs++;
      end
    end
    checks++;
    if (nhs != 5 || fifo_level !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_drained responses=%0d level=%0d busy=%b want 5/0/0", nhs, fifo_level, busy);
    end
  endtask

  task automatic test_tag_wrap;
    bit acc, vld, hs; rsp_t got; int lvl;
    int pushed = 0, nhs = 0;
    logic [7:0] last_tag = 8'hAA;
    rsp_t e;
    do_reset();
    io.rsp_ready = 1'b1;
    for (int c = 0; c < 1200 && (pushed < 257 || exp_q.size() != 0); c++) begin
      set_cmd(pushed < 257, 4'b0001, WIDTH'($urandom), WIDTH'($urandom));
      step(acc, vld, hs, got, lvl);
      if (acc) pushed++;
      if (hs) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        checks++;
        if (got !== e) begin errors++; $display("FAIL wrap_rsp%0d got=%h want=%h", nhs, got, e); end
        last_tag = got.tag;
        nhs++;
      end
    end
    io.cmd_valid = 1'b0;
    checks++;
    if (nhs != 257 || last_tag !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end responses=%0d last_tag=%h busy=%b want 257/00/0", nhs, last_tag, busy);
    end
  endtask

  task automatic test_mid_reset;
    bit acc, vld, hs; rsp_t got; int lvl;
    int nacc = 0;
    bit seen = 0;
    do_reset();
    io.rsp_ready = 1'b0;
    for (int c = 0; c < 10 && nacc < 4; c++) begin
      set_cmd(1, 4'b0011, WIDTH'($urandom), WIDTH'($urandom));
      step(acc, vld, hs, got, lvl);
      if (acc) nacc++;
    end
    io.cmd_valid = 1'b0;
    io.rsp_ready = 1'b1;
    for (int c = 0; c < 10 && !seen; c++) begin
      step(acc, vld, hs, got, lvl);
      seen = hs;
    end
    step(acc, vld, hs, got, lvl);
    checks++;
    if (fifo_level !== 3'd2 || io.rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mrst_pre level=%0d rsp_valid=%b busy=%b want 2/0/1", fifo_level, io.rsp_valid, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (io.rsp_valid !== 1'b0 || fifo_level !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mrst_async rsp_valid=%b level=%0d busy=%b want 0/0/0", io.rsp_valid, fifo_level, busy);
    end
    exp_q.delete();
    tb_tag = 8'd0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    set_cmd(1, 4'b0001, 16'h0005, 16'h0006);
    step(acc, vld, hs, got, lvl);
    io.cmd_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step(acc, vld, hs, got, lvl);
      seen = hs;
    end
    checks++;
    if (!seen || got !== {16'h000B, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL mrst_after hs=%b got=%h want data=000b err=0 tag=00", seen, got);
    end
    exp_q.delete();
  endtask

  task automatic test_random;
    bit acc, vld, hs; rsp_t got; int lvl;
    logic [3:0] op;
    logic [WIDTH-1:0] b;
    rsp_t e;
    for (int c = 0; c < 600 && (c < 300 || exp_q.size() != 0); c++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'(2 * $urandom_range(0, 3) + 1);
      b  = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom);
      set_cmd((c < 300) && ($urandom_range(0, 1) == 1), op, WIDTH'($urandom), b);
      io.rsp_ready = (c >= 300) || ($urandom_range(0, 2) != 0);
      checks++;
      if (io.cmd_ready !== (fifo_level != DEPTH)) begin
        errors++;
        $display("FAIL rnd_ready got=%b level=%0d", io.cmd_ready, fifo_level);
      end
      step(acc, vld, hs, got, lvl);
      if (vld) begin
        e = (exp_q.size() != 0) ? exp_q[0] : '1;
        checks++;
        if (got !== e) begin errors++; $display("FAIL rnd_rsp got=%h want=%h", got, e); end
        if (hs && exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
    io.cmd_valid = 1'b0;
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rnd_drain pending=%0d busy=%b want 0/0", exp_q.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_back_to_back();
    test_errors();
    test_backpressure();
    test_tag_wrap();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
